// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: serial FSM states, default width and
// the counter-width helper.
package arith_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DEF_WIDTH = 8;

  // Bits needed to count bit positions 0..w-1; never narrower than 1.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = arith_pkg::DEF_WIDTH);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             over_flow;

  modport master (output start, a, b, input busy, done, diff, borrow, over_flow);
  modport slave  (input start, a, b, output busy, done, diff, borrow, over_flow);
endinterface

// File: rtl/full_subtractor.sv
// 1-bit full subtractor cell: d = a - b - bin with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock through a single cell.
// Results are loaded only on completion, so partial sums never show.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);
  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr;
  logic             bor;
  logic             msb_bin;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             busy_q, done_q;
  logic             cell_d, cell_bout;

  full_subtractor u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (bor),
    .diff (cell_d),
    .bout (cell_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      d_sr     <= '0;
      bor      <= 1'b0;
      msb_bin  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            d_sr   <= '0;
            cnt    <= '0;
            bor    <= 1'b0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          d_sr <= {cell_d, d_sr[WIDTH-1:1]};
          bor  <= cell_bout;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            // Last bit: bor is the borrow into the MSB, cell_bout the one out.
            diff_q   <= {cell_d, d_sr[WIDTH-1:1]};
            borrow_q <= cell_bout;
            msb_bin  <= bor;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.over_flow = msb_bin ^ borrow_q;
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Sequential bit-serial two's-complement subtractor: computes a − b one bit per clock, LSB first, through a single 1-bit full-subtractor cell, and reports the difference with unsigned borrow and signed overflow. It is the subtraction counterpart of the team's ripple-carry 8-bit adder. It trades area for latency and sits behind a start/done handshake in the datapath's arithmetic unit.

## Interface
- WIDTH, default 8: operand and result width in bits; legal values are ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on a clk edge only in IDLE or DONE.
- a  input  WIDTH  minuend; latched on the accepted start edge.
- b  input  WIDTH  subtrahend; latched on the accepted start edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; the results are valid from this cycle onward.
- diff  output  WIDTH  a − b mod 2^WIDTH.
- borrow  output  1  unsigned borrow out of the MSB (a < b unsigned).
- over_flow  output  1  signed overflow: the borrow into the MSB XOR the borrow out of the MSB.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- IDLE → RUN on start=1. Latch a and b into shift registers, clear the bit counter and the borrow flop.
- RUN: each edge feeds bit 0 of the a and b shift registers and the borrow flop into the cell.
  - The cell computes d = a^b^bin and bout = (~a&b) | (~(a^b)&bin).
  - d shifts into the MSB of the diff shift register; both operand registers shift right; the counter increments.
  - The cell's bin for the MSB is kept in a flop for the overflow calculation.
- RUN → DONE on the edge that processes bit WIDTH−1. On that edge, load diff, borrow and over_flow from the shift register and cell.
- DONE → RUN if start=1 (back-to-back: latch new operands); otherwise DONE → IDLE.
- start in RUN is ignored; a and b are don't-care outside accepted start edges.
- The diff, borrow and over_flow outputs change only on the RUN→DONE edge. Partial results are never visible on them, and the values hold until the next completion.
- Arithmetic is modulo 2^WIDTH. The initial borrow-in is 0. No sign extension.

## Timing
- Reset, asynchronous, any state: state=IDLE, busy=0, done=0, diff=0, borrow=0, over_flow=0, counter=0, all internal shift registers=0.
- Reset mid-RUN aborts the operation; no done is produced.
- Start accepted at edge E0 → busy high from E0 to E0+WIDTH.
- done is high for exactly one cycle, between edges E0+WIDTH and E0+WIDTH+1. The latency is WIDTH edges.
- Throughput: with back-to-back starts, one result per WIDTH+1 cycles. The start sampled at the DONE edge makes busy high immediately after, while done still pulses for one cycle.
- The counter is ⌈log2(WIDTH)⌉ bits and must not wrap before the RUN→DONE transition.

## Structure
- Shared package `arith_pkg`: the state enum (IDLE, RUN, DONE), the default-width constant (8), and a function for the counter width.
- One sub-module, `full_subtractor`, which is purely combinational: outputs diff and bout; inputs a, b, bin. Instantiate it once, in the serial loop.
- The top level holds the FSM, counter, operand/diff shift registers, borrow flop, MSB-borrow-in flop and output registers.

## Test plan
- 0x05 − 0x03 → done 8 edges after start; diff=0x02, borrow=0, over_flow=0; busy high for 8 cycles.
- 0x03 − 0x05 → diff=0xFE, borrow=1, over_flow=0.
- 0x80 − 0x01 → diff=0x7F, borrow=0, over_flow=1.
- 0x7F − 0xFF → diff=0x80, borrow=1, over_flow=1.
- Start during RUN:
  - Start 0x10 − 0x01, then pulse start with 0xAA/0x55 at cycle 3 → ignored; result 0x0F.
  - Then hold start=1 in the DONE cycle with 0x00 − 0x00 → re-enter RUN; next done gives diff=0x00, borrow=0.
- Assert rst_n=0 at cycle 4 of RUN → all outputs become 0 immediately and no done pulse appears.
  - A fresh 0xFF − 0x01 afterwards → diff=0xFE, borrow=0, over_flow=0.
